// File: rtl/rvc_pkg.sv
// Shared encodings for the RVC fetch aligner and expander.
// Opcodes, funct3 codes and RVC quadrant/funct3 keys.
package rvc_pkg;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6f;
  localparam logic [6:0] JALR   = 7'h67;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] C_Q0 = 2'b00;
  localparam logic [1:0] C_Q1 = 2'b01;
  localparam logic [1:0] C_Q2 = 2'b10;

  localparam logic [2:0] CF_LW   = 3'b010;
  localparam logic [2:0] CF_SW   = 3'b110;
  localparam logic [2:0] CF_ADDI = 3'b000;
  localparam logic [2:0] CF_JAL  = 3'b001;
  localparam logic [2:0] CF_LI   = 3'b010;
  localparam logic [2:0] CF_MISC = 3'b100;
  localparam logic [2:0] CF_J    = 3'b101;
  localparam logic [2:0] CF_BEQZ = 3'b110;
  localparam logic [2:0] CF_BNEZ = 3'b111;
  localparam logic [2:0] CF_SLLI = 3'b000;
  localparam logic [2:0] CF_JR   = 3'b100;

  localparam logic [31:0] ILLEGAL_INS = 32'h0;

  function automatic logic is_rv32(
    input logic [15:0] h
  );
    return h[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/rvc_expander.sv
// Combinational RV32C -> RV32I expander.
// Flags reserved/unsupported encodings as illegal.
module rvc_expander
  import rvc_pkg::*;
#(
  parameter bit C_EN = 1'b1
) (
  input  logic [15:0] c,
  output logic [31:0] ins,
  output logic        illegal
);

  logic [4:0]  key;
  logic [4:0]  rd;
  logic [4:0]  rs2;
  logic [4:0]  r1p;
  logic [4:0]  r2p;
  logic [11:0] imm6;
  logic [6:0]  lwoff;
  logic [20:0] joff;
  logic [12:0] boff;

  assign key   = {c[1:0], c[15:13]};
  assign rd    = c[11:7];
  assign rs2   = c[6:2];
  assign r1p   = {2'b01, c[9:7]};
  assign r2p   = {2'b01, c[4:2]};
  assign imm6  = {{6{c[12]}}, c[12], c[6:2]};
  assign lwoff = {c[5], c[12:10], c[6], 2'b00};
  assign joff  = {{9{c[12]}}, c[12], c[8],
                  c[10:9], c[6], c[7], c[2],
                  c[11], c[5:3], 1'b0};
  assign boff  = {{4{c[12]}}, c[12], c[6:5],
                  c[2], c[11:10], c[4:3], 1'b0};

  always_comb begin
    ins     = ILLEGAL_INS;
    illegal = 1'b0;
    unique case (key)
      {C_Q0, CF_LW}:
        ins = {5'b0, lwoff, r1p, F3_W, r2p, LOAD};
      {C_Q0, CF_SW}:
        ins = {5'b0, lwoff[6:5], r2p, r1p,
               F3_W, lwoff[4:0], STORE};
      {C_Q1, CF_ADDI}:
        ins = {imm6, rd, F3_ADD, rd, OP_IMM};
      {C_Q1, CF_JAL}:
        ins = {joff[20], joff[10:1], joff[11],
               joff[19:12], 5'd1, JAL};
      {C_Q1, CF_LI}:
        ins = {imm6, 5'd0, F3_ADD, rd, OP_IMM};
      {C_Q1, CF_MISC}: begin
        unique case (c[11:10])
          2'b00: begin
            illegal = c[12];
            ins = {7'b0, c[6:2], r1p, F3_SR,
                   r1p, OP_IMM};
          end
          2'b01: begin
            illegal = c[12];
            ins = {7'b0100000, c[6:2], r1p,
                   F3_SR, r1p, OP_IMM};
          end
          2'b10:
            ins = {imm6, r1p, F3_AND, r1p, OP_IMM};
          default: illegal = 1'b1;
        endcase
      end
      {C_Q1, CF_J}:
        ins = {joff[20], joff[10:1], joff[11],
               joff[19:12], 5'd0, JAL};
      {C_Q1, CF_BEQZ}:
        ins = {boff[12], boff[10:5], 5'd0, r1p,
               F3_BEQ, boff[4:1], boff[11], BRANCH};
      {C_Q1, CF_BNEZ}:
        ins = {boff[12], boff[10:5], 5'd0, r1p,
               F3_BNE, boff[4:1], boff[11], BRANCH};
      {C_Q2, CF_SLLI}: begin
        illegal = c[12];
        ins = {7'b0, c[6:2], rd, F3_SLL, rd, OP_IMM};
      end
      {C_Q2, CF_JR}: begin
        // rs2 == 0 selects the jump forms; rd == 0 there is reserved/EBREAK
        if (rs2 == 5'd0) begin
          illegal = (rd == 5'd0);
          ins = {12'd0, rd, 3'b000,
                 {4'd0, c[12]}, JALR};
        end else if (!c[12]) begin
          ins = {7'b0, rs2, 5'd0, F3_ADD, rd, OP};
        end else begin
          ins = {7'b0, rs2, rd, F3_ADD, rd, OP};
        end
      end
      default: illegal = 1'b1;
    endcase
    if (!C_EN) illegal = 1'b1;
    if (illegal) ins = ILLEGAL_INS;
  end

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Halfword queue that realigns mixed 16/32-bit fetch words
// and presents one expanded RV32 instruction per cycle.
module rvc_fetch_aligner
  import rvc_pkg::*;
#(
  parameter int          QDEPTH   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          C_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc,
  output logic        ins_is_c,
  output logic        ins_illegal
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  logic [15:0]   q [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pc_q;
  logic          drop_lo;

  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          is32;
  logic [CW-1:0] need;
  logic [CW-1:0] n_push;
  logic [CW-1:0] free;
  logic          push;
  logic          pop;
  logic [31:0]   exp_data;
  logic          exp_ill;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input logic [1:0]    n
  );
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW-1){1'b0}}, n};
    if (s >= (PW+1)'(QDEPTH))
      s = s - (PW+1)'(QDEPTH);
    return s[PW-1:0];
  endfunction

  assign h0     = q[rd_ptr];
  assign h1     = q[wrap(rd_ptr, 2'd1)];
  assign is32   = is_rv32(h0);
  assign need   = is32 ? CW'(2) : CW'(1);
  assign n_push = drop_lo ? CW'(1) : CW'(2);
  assign free   = CW'(QDEPTH) - count;

  assign fetch_ready = free >= CW'(2);
  assign ins_valid   = count >= need;
  assign push = fetch_valid && fetch_ready && !flush;
  assign pop  = ins_valid && ins_ready && !flush;

  rvc_expander #(
    .C_EN(C_EN)
  ) u_exp (
    .c      (h0),
    .ins    (exp_data),
    .illegal(exp_ill)
  );

  assign ins_pc      = pc_q;
  assign ins_is_c    = ins_valid && !is32;
  assign ins_illegal = ins_valid && !is32 && exp_ill;
  assign ins_data    = !ins_valid ? ILLEGAL_INS :
                       is32 ? {h1, h0} : exp_data;

  // Storage only; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      if (drop_lo) begin
        q[wr_ptr] <= fetch_data[31:16];
      end else begin
        q[wr_ptr] <= fetch_data[15:0];
        q[wrap(wr_ptr, 2'd1)] <= fetch_data[31:16];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pc_q    <= RESET_PC;
      drop_lo <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pc_q    <= redirect_pc;
      drop_lo <= redirect_pc[1];
    end else begin
      if (push) begin
        wr_ptr  <= wrap(wr_ptr, n_push[1:0]);
        drop_lo <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= wrap(rd_ptr, need[1:0]);
        pc_q   <= pc_q + (is32 ? 32'd4 : 32'd2);
      end
      count <= count
             + (push ? n_push : CW'(0))
             - (pop ? need : CW'(0));
    end
  end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Randomized bench for rvc_fetch_aligner with a
// halfword-queue reference model and directed vectors.
module tb_rvc_fetch_aligner;

  localparam int QD = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fv  = 1'b0;
  logic        fr;
  logic [31:0] fd  = '0;
  logic        fl  = 1'b0;
  logic [31:0] rpc = '0;
  logic        iv;
  logic        ir  = 1'b0;
  logic [31:0] idata;
  logic [31:0] ipc;
  logic        isc;
  logic        iill;

  logic        c0_fv = 1'b0;
  logic        c0_fr;
  logic [31:0] c0_fd = '0;
  logic        c0_iv;
  logic [31:0] c0_data;
  logic [31:0] c0_pc;
  logic        c0_isc;
  logic        c0_ill;

  int checks = 0;
  int errors = 0;

  logic [15:0] mq [$];
  logic [31:0] mpc = '0;
  bit          mdrop = 1'b0;

  always #5 clk = ~clk;

  rvc_fetch_aligner #(
    .QDEPTH(QD), .RESET_PC(32'h0), .C_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fv), .fetch_ready(fr),
    .fetch_data(fd), .flush(fl),
    .redirect_pc(rpc), .ins_valid(iv),
    .ins_ready(ir), .ins_data(idata),
    .ins_pc(ipc), .ins_is_c(isc),
    .ins_illegal(iill)
  );

  rvc_fetch_aligner #(
    .QDEPTH(QD), .RESET_PC(32'h0), .C_EN(1'b0)
  ) dut_c0 (
    .clk(clk), .rst(rst),
    .fetch_valid(c0_fv), .fetch_ready(c0_fr),
    .fetch_data(c0_fd), .flush(1'b0),
    .redirect_pc(32'h0), .ins_valid(c0_iv),
    .ins_ready(1'b0), .ins_data(c0_data),
    .ins_pc(c0_pc), .ins_is_c(c0_isc),
    .ins_illegal(c0_ill)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(
    input int imm, input int rs1, input int f3,
    input int rd, input int op
  );
    logic [31:0] u;
    u = imm;
    return {u[11:0], rs1[4:0], f3[2:0],
            rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(
    input int imm, input int rs2, input int rs1
  );
    logic [31:0] u;
    u = imm;
    return {u[11:5], rs2[4:0], rs1[4:0], 3'd2,
            u[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(
    input int imm, input int rs1, input int f3
  );
    logic [31:0] u;
    u = imm;
    return {u[12], u[10:5], 5'd0, rs1[4:0], f3[2:0],
            u[4:1], u[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(
    input int imm, input int rd
  );
    logic [31:0] u;
    u = imm;
    return {u[20], u[10:1], u[11], u[19:12],
            rd[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] enc_r(
    input int rs2, input int rs1, input int rd
  );
    return {7'd0, rs2[4:0], rs1[4:0], 3'd0,
            rd[4:0], 7'h33};
  endfunction

  // Field-level decode of the RV32C subset, re-encoded via RV32I formats
  function automatic void ref_exp(
    input  logic [15:0] h,
    input  bit          cen,
    output logic [31:0] d,
    output bit          ill
  );
    int f, rd, rs2, r1p, r2p, imm, off, sh;
    f   = int'(h[15:13]);
    rd  = int'(h[11:7]);
    rs2 = int'(h[6:2]);
    r1p = 8 + int'(h[9:7]);
    r2p = 8 + int'(h[4:2]);
    sh  = int'(h[6:2]);
    imm = sh - (h[12] ? 32 : 0);
    d   = 32'h0;
    ill = 1'b0;
    case (h[1:0])
      2'b00: begin
        off = int'(h[6]) * 4 + int'(h[12:10]) * 8
            + int'(h[5]) * 64;
        if (f == 2) d = enc_i(off, r1p, 2, r2p, 'h03);
        else if (f == 6) d = enc_s(off, r2p, r1p);
        else ill = 1'b1;
      end
      2'b01: begin
        case (f)
          0: d = enc_i(imm, rd, 0, rd, 'h13);
          2: d = enc_i(imm, 0, 0, rd, 'h13);
          1, 5: begin
            off = int'(h[5:3]) * 2 + int'(h[11]) * 16
                + int'(h[2]) * 32 + int'(h[7]) * 64
                + int'(h[6]) * 128
                + int'(h[10:9]) * 256
                + int'(h[8]) * 1024
                - int'(h[12]) * 2048;
            d = enc_j(off, (f == 1) ? 1 : 0);
          end
          4: begin
            case (h[11:10])
              2'b00:
                if (h[12]) ill = 1'b1;
                else d = enc_i(sh, r1p, 5, r1p, 'h13);
              2'b01:
                if (h[12]) ill = 1'b1;
                else d = enc_i(sh + 'h400, r1p, 5,
                               r1p, 'h13);
              2'b10: d = enc_i(imm, r1p, 7, r1p, 'h13);
              default: ill = 1'b1;
            endcase
          end
          6, 7: begin
            off = int'(h[4:3]) * 2 + int'(h[11:10]) * 8
                + int'(h[2]) * 32 + int'(h[6:5]) * 64
                - int'(h[12]) * 256;
            d = enc_b(off, r1p, (f == 6) ? 0 : 1);
          end
          default: ill = 1'b1;
        endcase
      end
      2'b10: begin
        if (f == 0) begin
          if (h[12]) ill = 1'b1;
          else d = enc_i(sh, rd, 1, rd, 'h13);
        end else if (f == 4) begin
          if (rs2 == 0 && rd == 0) ill = 1'b1;
          else if (rs2 == 0)
            d = enc_i(0, rd, 0, h[12] ? 1 : 0, 'h67);
          else if (!h[12]) d = enc_r(rs2, 0, rd);
          else d = enc_r(rs2, rd, rd);
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    if (!cen) ill = 1'b1;
    if (ill) d = 32'h0;
  endfunction

  // Drive one cycle, check outputs against the model, advance both
  task automatic cyc(
    input bit v, input logic [31:0] d,
    input bit r, input bit f,
    input logic [31:0] p
  );
    bit er, ev, e32, push, pop, eill;
    logic [15:0] h0;
    logic [31:0] ed;
    fv = v; fd = d; ir = r; fl = f; rpc = p;
    #1;
    er  = (QD - mq.size()) >= 2;
    h0  = (mq.size() > 0) ? mq[0] : 16'h0;
    e32 = (h0[1:0] == 2'b11);
    ev  = mq.size() >= (e32 ? 2 : 1);
    chk("fetch_ready", 32'(fr), 32'(er));
    chk("ins_valid", 32'(iv), 32'(ev));
    chk("ins_pc", ipc, mpc);
    if (ev) begin
      if (e32) begin
        ed = {mq[1], h0};
        eill = 1'b0;
      end else begin
        ref_exp(h0, 1'b1, ed, eill);
      end
      chk("ins_data", idata, ed);
      chk("ins_is_c", 32'(isc), 32'(!e32));
      chk("ins_illegal", 32'(iill), 32'(eill));
    end
    push = v && er && !f;
    pop  = ev && r && !f;
    if (f) begin
      mq.delete();
      mpc   = p;
      mdrop = p[1];
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        if (e32) void'(mq.pop_front());
        mpc = mpc + (e32 ? 32'd4 : 32'd2);
      end
      if (push) begin
        if (!mdrop) mq.push_back(d[15:0]);
        mq.push_back(d[31:16]);
        mdrop = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd_pc;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(iv), 32'h0);
    chk("rst_fready", 32'(fr), 32'h1);
    chk("rst_data", idata, 32'h0);
    chk("rst_is_c", 32'(isc), 32'h0);
    chk("rst_illegal", 32'(iill), 32'h0);
    chk("rst_pc", ipc, 32'h0);
    @(negedge clk);

    cyc(1, 32'h0505_0001, 1, 0, 0);
    chk("nop_data", idata, 32'h0000_0013);
    chk("nop_is_c", 32'(isc), 32'h1);
    cyc(0, 0, 1, 0, 0);
    chk("addi_data", idata, 32'h0015_0513);
    chk("addi_pc", ipc, 32'h2);
    cyc(0, 0, 1, 0, 0);
    chk("drained", 32'(iv), 32'h0);

    cyc(0, 0, 1, 1, 32'h0);
    cyc(1, 32'h0093_0001, 1, 0, 0);
    chk("span_nop", idata, 32'h0000_0013);
    cyc(0, 0, 1, 0, 0);
    chk("split_wait", 32'(iv), 32'h0);
    cyc(1, 32'h8082_0050, 1, 0, 0);
    chk("span_data", idata, 32'h0050_0093);
    chk("span_pc", ipc, 32'h2);
    chk("span_is_c", 32'(isc), 32'h0);
    cyc(0, 0, 1, 0, 0);
    chk("jr_data", idata, 32'h0000_8067);
    chk("jr_pc", ipc, 32'h6);
    cyc(0, 0, 1, 0, 0);

    cyc(0, 0, 1, 1, 32'h0);
    for (int i = 0; i < 4; i++)
      cyc(1, 32'h0505_0001, 0, 0, 0);
    chk("bp_fready", 32'(fr), 32'h0);
    chk("bp_hold", idata, 32'h0000_0013);
    for (int i = 0; i < 7; i++)
      cyc(0, 0, 1, 0, 0);
    chk("bp_pc", ipc, 32'd12);

    cyc(1, 32'h0505_0001, 0, 0, 0);
    cyc(1, 32'h1234_5678, 0, 1, 32'h102);
    chk("fl_valid", 32'(iv), 32'h0);
    cyc(1, 32'h852E_FFFF, 0, 0, 0);
    chk("fl_pc", ipc, 32'h102);
    chk("fl_data", idata, 32'h00B0_0533);
    cyc(0, 0, 1, 0, 0);
    chk("fl_empty", 32'(iv), 32'h0);

    cyc(1, 32'h0000_0000, 0, 0, 0);
    chk("ill0_flag", 32'(iill), 32'h1);
    chk("ill0_data", idata, 32'h0);
    cyc(0, 0, 1, 0, 0);
    chk("ill1_flag", 32'(iill), 32'h1);
    chk("ill1_pc", ipc, 32'h106);
    cyc(0, 0, 1, 0, 0);
    chk("ill_pc", ipc, 32'h108);

    c0_fv = 1'b1;
    c0_fd = 32'h0505_0001;
    cyc(0, 0, 0, 0, 0);
    c0_fv = 1'b0;
    #1;
    chk("c0_valid", 32'(c0_iv), 32'h1);
    chk("c0_illegal", 32'(c0_ill), 32'h1);
    chk("c0_data", c0_data, 32'h0);

    cyc(0, 0, 0, 1, 32'h102);
    cyc(1, 32'h0505_0001, 0, 0, 0);
    cyc(1, 32'h0505_0001, 0, 0, 0);
    chk("ar_pre_valid", 32'(iv), 32'h1);
    fv = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(iv), 32'h0);
    chk("ar_fready", 32'(fr), 32'h1);
    mq.delete();
    mpc = 32'h0;
    mdrop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_pc", ipc, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      rd_pc = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 3) == 0)
        rd_pc = 32'hFFFF_FFF8 | (rd_pc & 32'h6);
      cyc($urandom_range(0, 9) < 7, $urandom,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 49) == 0, rd_pc);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
